uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning the inter-byte timeout in CLK cycles.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data, input, 8 bits: received byte from the UART core.
REQ-006 SHALL have port rx_valid, input, 1 bit: single-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tx_data, output, 8 bits: response byte to the UART core.
REQ-008 SHALL have port tx_valid, output, 1 bit: response byte valid.
REQ-009 SHALL have port tx_ready, input, 1 bit: the UART core accepts the byte.
REQ-010 SHALL have port cmd_valid, output, 1 bit: bus command pending.
REQ-011 SHALL have port cmd_ready, input, 1 bit: bus command accepted.
REQ-012 SHALL have port cmd_write, output, 1 bit: 1 = write, 0 = read.
REQ-013 SHALL have port cmd_addr, output, 16 bits: command address.
REQ-014 SHALL have port cmd_wdata, output, 16 bits: write data.
REQ-015 SHALL have port rd_valid, input, 1 bit: single-cycle strobe qualifying rd_data.
REQ-016 SHALL have port rd_data, input, 16 bits: read return data.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 SHALL have port overrun, output, 1 bit: sticky flag for a byte dropped while not receiving.

Function
REQ-019 SHALL use the frame SYNC, OP, ADDR_H, ADDR_L, DATA_H, DATA_L, CHK, where CHK = XOR of OP through DATA_L.
REQ-020 SHALL use OP values 8'h01 = WRITE and 8'h02 = READ; DATA bytes are present but ignored for READ.
REQ-021 SHALL implement the states IDLE, RECV, CHECK, ISSUE, WAIT_RD, RESP.
REQ-022 SHALL, in IDLE, discard bytes not equal to SYNC_BYTE; on SYNC_BYTE, go to RECV with byte index 0 and checksum 0.
REQ-023 SHALL, in RECV, store each rx_valid byte by index, XOR it into the running checksum, and go to CHECK on the 6th byte (CHK).
REQ-024 SHALL, in CHECK (one cycle), go to ISSUE if the checksum matches and OP is legal; otherwise load the NAK response (8'h15) and go to RESP.
REQ-025 SHALL, in ISSUE, hold cmd_valid=1 with stable cmd_write/cmd_addr/cmd_wdata until the cycle cmd_valid && cmd_ready.
REQ-026 SHALL, on that handshake, load the ACK response (8'h06) for WRITE and go to RESP, or go to WAIT_RD for READ.
REQ-027 SHALL, in WAIT_RD, on rd_valid, load the response 8'h06, rd_data[15:8], rd_data[7:0] and go to RESP.
REQ-028 SHALL, in RESP, present bytes in order with tx_valid=1 and advance only on tx_valid && tx_ready.
REQ-029 SHALL return to IDLE after the last response byte is accepted.
REQ-030 SHALL use a timeout counter that resets on each rx_valid in RECV; if it reaches TIMEOUT_CYC-1 while in RECV, go to IDLE with no response and no command.
REQ-031 SHALL not time out in ISSUE, WAIT_RD or RESP; it waits indefinitely.
REQ-032 SHALL, on rx_valid in CHECK/ISSUE/WAIT_RD/RESP, drop the byte and set overrun=1; overrun clears only on reset.
REQ-033 SHALL, for rx_valid in the same cycle as the RESP-to-IDLE transition, drop the byte and set overrun.
REQ-034 SHALL ignore rd_valid outside WAIT_RD.
REQ-035 SHALL drive tx_valid=0 outside RESP and cmd_valid=0 outside ISSUE.

Reset
REQ-036 SHALL, while rst=0, force state IDLE and clear all outputs to 0 (tx_data, tx_valid, cmd_valid, cmd_write, cmd_addr, cmd_wdata, busy, overrun), along with the counters and checksum.
REQ-037 SHALL abandon any partial frame, pending command or response on reset assertion mid-operation, with no further tx/cmd activity.

Structure
REQ-038 SHALL place the state encoding, OP codes (WRITE, READ), ACK/NAK bytes and frame length (7) as constants in shared package uart_cmd_pkg.
REQ-039 SHALL implement the response shift buffer (3 bytes plus count) as sub-module uart_resp_buf; all else is inline.

Verification
REQ-040 SHALL cover: RX A5 01 12 34 BE EF 76 -> one cmd_valid with write=1, addr=16'h1234, wdata=16'hBEEF; after cmd_ready, TX 06.
REQ-041 SHALL cover: RX A5 02 00 10 00 00 12, cmd_ready, rd_valid with rd_data=16'hCAFE -> TX 06 CA FE; tx_ready held low 5 cycles mid-response -> same bytes, none repeated.
REQ-042 SHALL cover: RX A5 01 12 34 BE EF 00 (bad CHK) -> TX 15, cmd_valid never asserted; also RX A5 07 00 00 00 00 07 -> TX 15.
REQ-043 SHALL cover: RX 00 FF A5 01 12 34, then silence for TIMEOUT_CYC (set to 100) -> busy falls, no TX/cmd; the next valid frame is processed normally.
REQ-044 SHALL cover: a byte injected during WAIT_RD -> overrun=1, the response is unaffected; rst=0 -> overrun=0.
REQ-045 SHALL cover: rst asserted mid-RESP (after 06 of a read) -> tx_valid=0 immediately, remaining bytes never sent.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: FSM encoding, opcodes,
// response bytes and frame geometry.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT_RD = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  // SYNC plus six body bytes (OP, ADDR_H, ADDR_L, DATA_H, DATA_L, CHK)
  localparam int FRAME_LEN = 7;
  localparam int BODY_LEN  = FRAME_LEN - 1;

  function automatic logic op_is_legal(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/uart_resp_buf.sv
// Response shift buffer: up to three bytes loaded at once, presented
// head-first and shifted out one byte per accepted transfer.
module uart_resp_buf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [1:0]  load_cnt_i,
  input  logic [23:0] load_bytes_i,
  input  logic        pop_i,
  output logic [7:0]  head_o,
  output logic        last_o
);

  logic [23:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;

  // Byte storage and remaining-byte count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  // Load takes priority; a pop shifts the next byte into the head slot
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (load_i) begin
      buf_d = load_bytes_i;
      cnt_d = load_cnt_i;
    end else if (pop_i && (cnt_q != 2'd0)) begin
      buf_d = {buf_q[15:0], 8'h00};
      cnt_d = cnt_q - 2'd1;
    end
  end

  assign head_o = buf_q[23:16];
  assign last_o = (cnt_q == 2'd1);

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command parser: receives SYNC/OP/ADDR/DATA/CHK frames,
// issues a bus read or write, and returns ACK/NAK (plus read data).
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       LAST_IDX = 3'(BODY_LEN - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       op_q, op_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] tocnt_q, tocnt_d;
  logic             overrun_q, overrun_d;

  logic             frame_ok;
  logic             resp_load;
  logic [1:0]       resp_cnt;
  logic [23:0]      resp_bytes;
  logic             resp_last;

  // Running XOR includes CHK itself, so a good frame leaves zero
  assign frame_ok = (chk_q == 8'h00) && op_is_legal(op_q);

  // State register
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_RECV;
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (idx_q == LAST_IDX) state_d = ST_CHECK;
        end else if (tocnt_q == TO_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        state_d = frame_ok ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = (op_q == OP_WRITE) ? ST_RESP : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (rd_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (tx_ready && resp_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode and response-buffer load requests
  always_comb begin
    cmd_valid  = (state_q == ST_ISSUE);
    tx_valid   = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
    resp_load  = 1'b0;
    resp_cnt   = 2'd0;
    resp_bytes = 24'h000000;
    case (state_q)
      ST_CHECK: begin
        if (!frame_ok) begin
          resp_load  = 1'b1;
          resp_cnt   = 2'd1;
          resp_bytes = {RESP_NAK, 16'h0000};
        end
      end
      ST_ISSUE: begin
        if (cmd_ready && (op_q == OP_WRITE)) begin
          resp_load  = 1'b1;
          resp_cnt   = 2'd1;
          resp_bytes = {RESP_ACK, 16'h0000};
        end
      end
      ST_WAIT_RD: begin
        if (rd_valid) begin
          resp_load  = 1'b1;
          resp_cnt   = 2'd3;
          resp_bytes = {RESP_ACK, rd_data};
        end
      end
      default: ;
    endcase
  end

  // Frame capture, checksum, inter-byte timeout and overrun next values
  always_comb begin
    idx_d     = idx_q;
    chk_d     = chk_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tocnt_d   = tocnt_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          idx_d   = 3'd0;
          chk_d   = 8'h00;
          tocnt_d = '0;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          idx_d   = idx_q + 3'd1;
          chk_d   = chk_q ^ rx_data;
          tocnt_d = '0;
          case (idx_q)
            3'd0:    op_d           = rx_data;
            3'd1:    addr_d[15:8]   = rx_data;
            3'd2:    addr_d[7:0]    = rx_data;
            3'd3:    wdata_d[15:8]  = rx_data;
            3'd4:    wdata_d[7:0]   = rx_data;
            default: ;
          endcase
        end else if (tocnt_q != TO_LAST) begin
          tocnt_d = tocnt_q + CNT_W'(1);
        end
      end
      // Anything arriving while a frame is being handled is lost
      ST_CHECK, ST_ISSUE, ST_WAIT_RD, ST_RESP: begin
        if (rx_valid) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame and status registers
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      idx_q     <= '0;
      chk_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tocnt_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tocnt_q   <= tocnt_d;
      overrun_q <= overrun_d;
    end
  end

  uart_resp_buf u_resp_buf (
    .clk_i        (CLK),
    .rst_ni       (rst),
    .load_i       (resp_load),
    .load_cnt_i   (resp_cnt),
    .load_bytes_i (resp_bytes),
    .pop_i        (tx_valid && tx_ready),
    .head_o       (tx_data),
    .last_o       (resp_last)
  );

  // Frame fields only change while receiving, so they stay stable in ISSUE
  assign cmd_write = (op_q == OP_WRITE);
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame table plus hand-written timeout,
// overrun and mid-response reset sequences, with a cmd/tx scoreboard.
module tb_uart_cmd_parser;

  localparam int TO_CYC = 100;

  logic        CLK = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        busy;
  logic        overrun;

  always #5 CLK = ~CLK;

  uart_cmd_parser #(.TIMEOUT_CYC(TO_CYC), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic [55:0] frame;
    bit          has_cmd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdd;
    int          ntx;
    logic [23:0] tx;
    bit          stall;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  vec_t       vecs[6];
  cmd_t       cmd_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard side: compares every cmd/tx handshake against the queues
  task automatic monitor();
    cmd_t       ec;
    logic [7:0] et;
    forever begin
      @(negedge CLK);
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 32'(cmd_addr), 32'hFFFF_FFFF);
        end else if (cmd_ready) begin
          ec = cmd_q.pop_front();
          check("cmd_write", 32'(cmd_write), 32'(ec.wr));
          check("cmd_addr", 32'(cmd_addr), 32'(ec.addr));
          if (ec.wr) check("cmd_wdata", 32'(cmd_wdata), 32'(ec.wdata));
        end
      end
      if (tx_valid) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        end else if (tx_ready) begin
          et = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(et));
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input vec_t v);
    logic [55:0] f;
    f = v.frame;
    for (int k = 0; k < 7; k++) send_byte(f[55-8*k -: 8]);
  endtask

  task automatic push_vec(input vec_t v);
    cmd_t        c;
    logic [23:0] t;
    t = v.tx;
    for (int k = 0; k < v.ntx; k++) tx_q.push_back(t[23-8*k -: 8]);
    if (v.has_cmd) begin
      c.wr = v.wr; c.addr = v.addr; c.wdata = v.wdata;
      cmd_q.push_back(c);
    end
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!cmd_valid && n < 50) begin tick(); n++; end
    check("cmd_wait", 32'(cmd_valid), 32'd1);
  endtask

  task automatic handshake_cmd();
    wait_cmd();
    tick(); tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_txq_left"}, 32'(tx_q.size()), 32'd0);
    check({tag, "_cmdq_left"}, 32'(cmd_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    push_vec(v);
    send_frame(v);
    if (v.has_cmd) begin
      handshake_cmd();
      if (!v.wr) begin
        if (v.stall) tx_ready = 1'b0;
        tick(); tick();
        rd_valid = 1'b1;
        rd_data  = v.rdd;
        tick();
        rd_valid = 1'b0;
        rd_data  = 16'h0000;
        if (v.stall) begin
          tick();
          tx_ready = 1'b1;
          tick();
          tx_ready = 1'b0;
          repeat (5) tick();
          tx_ready = 1'b1;
        end
      end
    end
    wait_idle();
    check_drained("vec");
  endtask

  initial begin
    int n;
    vecs[0] = '{frame: 56'hA5_01_12_34_BE_EF_76, has_cmd: 1, wr: 1, addr: 16'h1234,
                wdata: 16'hBEEF, rdd: 16'h0000, ntx: 1, tx: 24'h06_00_00, stall: 0};
    vecs[1] = '{frame: 56'hA5_02_00_10_00_00_12, has_cmd: 1, wr: 0, addr: 16'h0010,
                wdata: 16'h0000, rdd: 16'hCAFE, ntx: 3, tx: 24'h06_CA_FE, stall: 1};
    vecs[2] = '{frame: 56'hA5_01_12_34_BE_EF_00, has_cmd: 0, wr: 0, addr: 16'h0000,
                wdata: 16'h0000, rdd: 16'h0000, ntx: 1, tx: 24'h15_00_00, stall: 0};
    vecs[3] = '{frame: 56'hA5_07_00_00_00_00_07, has_cmd: 0, wr: 0, addr: 16'h0000,
                wdata: 16'h0000, rdd: 16'h0000, ntx: 1, tx: 24'h15_00_00, stall: 0};
    vecs[4] = '{frame: 56'hA5_01_FF_FF_00_01_00, has_cmd: 1, wr: 1, addr: 16'hFFFF,
                wdata: 16'h0001, rdd: 16'h0000, ntx: 1, tx: 24'h06_00_00, stall: 0};
    vecs[5] = '{frame: 56'hA5_02_AB_CD_55_55_64, has_cmd: 1, wr: 0, addr: 16'hABCD,
                wdata: 16'h5555, rdd: 16'h1234, ntx: 3, tx: 24'h06_12_34, stall: 0};

    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = 16'h0000;

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_write", 32'(cmd_write), 32'd0);
    check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst_cmd_wdata", 32'(cmd_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    tick();

    // Frame table
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("table_overrun", 32'(overrun), 32'd0);

    // Inter-byte timeout: junk, then a truncated frame, then silence
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    check("to_busy_recv", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    check("to_busy_fall", 32'(busy), 32'd0);
    check("to_length_ok", 32'((n >= TO_CYC - 1) && (n <= TO_CYC + 1)), 32'd1);
    check("to_overrun", 32'(overrun), 32'd0);
    check_drained("to");
    run_vec(vecs[0]);

    // Byte injected while waiting for read data
    push_vec(vecs[5]);
    send_frame(vecs[5]);
    handshake_cmd();
    send_byte(8'h5A);
    check("ovr_set", 32'(overrun), 32'd1);
    tick();
    rd_valid = 1'b1; rd_data = vecs[5].rdd;
    tick();
    rd_valid = 1'b0; rd_data = 16'h0000;
    wait_idle();
    check("ovr_sticky", 32'(overrun), 32'd1);
    check_drained("ovr");
    rst = 1'b0;
    #1;
    check("ovr_cleared", 32'(overrun), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Reset asserted after the ACK of a read response went out
    push_vec(vecs[1]);
    send_frame(vecs[1]);
    handshake_cmd();
    tx_ready = 1'b0;
    tick();
    rd_valid = 1'b1; rd_data = 16'hCAFE;
    tick();
    rd_valid = 1'b0; rd_data = 16'h0000;
    tick();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("mid_tx_valid", 32'(tx_valid), 32'd1);
    check("mid_tx_data", 32'(tx_data), 32'hCA);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_tx_valid", 32'(tx_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tx_data", 32'(tx_data), 32'd0);
    check("rstmid_left", 32'(tx_q.size()), 32'd2);
    tx_q.delete();
    tx_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check_drained("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
